// File: rtl/rhs_op_infer_if.sv
// Sample/result bundle for rhs_op_infer.
// master drives samples and start; slave returns the inferred table.
interface rhs_op_infer_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] lhs_in;
   logic [WIDTH-1:0] rhs_in;
   logic [WIDTH-1:0] res_in;
   logic [3:0]       op_out;
   logic [3:0]       known_mask;
   logic             done;
   logic             conflict;
   logic [7:0]       sample_count;

   modport master (
      output start, in_valid, lhs_in, rhs_in, res_in,
      input  in_ready, op_out, known_mask,
      input  done, conflict, sample_count
   );

   modport slave (
      input  start, in_valid, lhs_in, rhs_in, res_in,
      output in_ready, op_out, known_mask,
      output done, conflict, sample_count
   );
endinterface

// File: rtl/rhs_op_infer.sv
// Infers a 2-input logic op truth table from (lhs, rhs, res) samples.
// Ports: clk, reset (async, high), bus (slave: samples in, table out).
module rhs_op_infer #(
   parameter int WIDTH = 8
) (
   input logic          clk,
   input logic          reset,
   rhs_op_infer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE,
      CONFLICT
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic [3:0] mask_q, mask_d;
   logic [7:0] cnt_q, cnt_d;

   logic [3:0] has1, has0, seen;
   logic [1:0] idx;
   logic       bad;
   logic       ready;
   logic       accept;

   assign ready  = (state_q == COLLECT) && !bus.start;
   assign accept = ready && bus.in_valid;

   // Which table entries this sample shows as 1 and as 0.
   always_comb begin
      has1 = '0;
      has0 = '0;
      idx  = '0;
      for (int k = 0; k < WIDTH; k++) begin
         idx = {bus.rhs_in[k], bus.lhs_in[k]};
         if (bus.res_in[k]) has1[idx] = 1'b1;
         else               has0[idx] = 1'b1;
      end
   end

   assign seen = has1 | has0;

   // Same entry seen both ways, or disagreeing with a stored entry.
   assign bad = (|(has1 & has0)) ||
                (|(seen & mask_q & (has1 ^ op_q)));

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      if (bus.start) begin
         state_d = COLLECT;
         op_d    = '0;
         mask_d  = '0;
         cnt_d   = '0;
      end else if (accept) begin
         if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
         if (bad) begin
            state_d = CONFLICT;
         end else begin
            op_d   = (op_q & ~seen) | has1;
            mask_d = mask_q | seen;
            if (mask_d == 4'hF) state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready     = ready;
   assign bus.op_out       = op_q;
   assign bus.known_mask   = mask_q;
   assign bus.done         = (state_q == DONE);
   assign bus.conflict     = (state_q == CONFLICT);
   assign bus.sample_count = cnt_q;

endmodule

// File: doc/rhs_op_infer.md
RHS_OP_INFER -- requirements
Module: rhs_op_infer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand/result bus width in bits.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  clear all collected state and begin a new inference.
REQ-005 SHALL have port in_valid  input  1  a sample (lhs_in, rhs_in, res_in) is presented.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port lhs_in  input  WIDTH  observed A operand.
REQ-008 SHALL have port rhs_in  input  WIDTH  observed B operand.
REQ-009 SHALL have port res_in  input  WIDTH  observed logic-unit result.
REQ-010 SHALL have port op_out  output  4  inferred rhs operation code; unknown bits read 0.
REQ-011 SHALL have port known_mask  output  4  bit i set once truth-table entry i has been observed.
REQ-012 SHALL have port done  output  1  all four entries known, no conflict.
REQ-013 SHALL have port conflict  output  1  contradictory observations seen.
REQ-014 SHALL have port sample_count  output  8  accepted samples since the last start.

Function
REQ-015 SHALL index the truth table as idx = {rhs_in[k], lhs_in[k]}, so op_out[idx] equals res_in[k] (AND=1000, A pass=1010, B pass=1100, NOR=0001).
REQ-016 SHALL implement states IDLE, COLLECT, DONE, CONFLICT.
REQ-017 SHALL move from any state to COLLECT on start, clearing op_out, known_mask, sample_count, and conflict.
REQ-018 SHALL drive in_ready high only in COLLECT and only while start is low.
REQ-019 SHALL accept a sample on a cycle with in_valid and in_ready both high.
REQ-020 SHALL give start priority over a same-cycle in_valid; that sample is neither accepted nor counted.
REQ-021 SHALL, for an accepted sample, evaluate all WIDTH bit positions in that cycle and set known_mask[idx] and op_out[idx] for every idx present.
REQ-022 SHALL flag a conflict when, within one sample, two bit positions with the same idx carry different res_in values.
REQ-023 SHALL flag a conflict when a sample's value for an already-known idx differs from the stored op_out[idx].
REQ-024 SHALL, on a conflict, enter CONFLICT with conflict=1 and leave op_out and known_mask unchanged from before that sample.
REQ-025 SHALL, when known_mask becomes 1111 without conflict, enter DONE with done=1.
REQ-026 SHALL update all outputs on the clock edge that accepts the sample, giving 1-cycle latency.
REQ-027 SHALL hold done/conflict and all outputs in DONE and CONFLICT until the next start, with in_ready low.
REQ-028 SHALL increment sample_count by one per accepted sample, including the conflicting one, and saturate at 255.
REQ-029 SHALL keep done and conflict mutually exclusive.

Reset
REQ-030 SHALL, on reset, immediately enter IDLE and drive in_ready=0, op_out=0000, known_mask=0000, done=0, conflict=0, sample_count=0.
REQ-031 SHALL, on reset during COLLECT, discard all partial results; a new start is required.

Verification
REQ-032 SHALL verify: start, then sample lhs=AA rhs=CC res=88 -> next cycle op_out=1000, known_mask=1111, done=1, sample_count=1, in_ready=0.
REQ-033 SHALL verify: start, then samples (FF,00,FF), (00,FF,00), (00,00,00), (FF,FF,FF) in sequence -> masks 0010, 0110, 0111, 1111; final op_out=1010, done=1, sample_count=4.
REQ-034 SHALL verify: start, then (FF,00,FF) followed by (FF,00,00) -> conflict=1, op_out=0010, known_mask=0010, sample_count=2, done=0.
REQ-035 SHALL verify: start, then the single sample lhs=03 rhs=00 res=01 -> intra-sample conflict, conflict=1, known_mask=0000.
REQ-036 SHALL verify: start and in_valid high in the same cycle with AA/CC/88 -> sample ignored, sample_count=0, and the sample is accepted on the following cycle.
REQ-037 SHALL verify: reset asserted after one sample in COLLECT -> all outputs zero at once, IDLE, and in_ready=0 until start.
